vga_pattern_engine: RTL

//   Parametrised animated test-pattern generator for the TinyVGA output path. Sits

---
 rtl/vga_pattern_engine.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vga_pattern_engine.sv
// -----------------------------------------------------------------------------
// vga_pattern_engine
//   Animated test-pattern generator for the TinyVGA output path. Takes the pixel
//   coordinates from hvsync_generator and produces registered RGB. A scroll offset
//   advances once per frame. Mode, speed, direction and pause are sampled only on
//   the frame tick, so changing them mid-frame never tears the picture.
//
// Ports
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   vsync        in   vsync from hvsync_generator (clk domain, never used as a clock)
//   video_active in   display_on from hvsync_generator
//   pix_x, pix_y in   current pixel column / row (COORD_W)
//   mode         in   pattern select (0 bars, 1 checker, 2 xor, 3 fade)
//   speed        in   scroll step per frame, 0..7
//   dir          in   0: scroll up, 1: scroll down
//   pause        in   1: hold scroll_cnt
//   r, g, b      out  registered colour channels (COLOR_W), 1 clk after pixel inputs
//   frame_tick   out  1-cycle pulse the cycle after each vsync assertion
//   frame_cnt    out  free-running frame count (CNT_W)
//   scroll_cnt   out  current scroll offset (CNT_W)
// -----------------------------------------------------------------------------
module vga_pattern_engine #(
   parameter int COORD_W       = 10,
   parameter int COLOR_W       = 2,
   parameter int CNT_W         = 10,
   parameter int SHIFT         = 4,
   parameter int VSYNC_ACT_LOW = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vsync,
   input  logic               video_active,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   input  logic [1:0]         mode,
   input  logic [2:0]         speed,
   input  logic               dir,
   input  logic               pause,
   output logic [COLOR_W-1:0] r,
   output logic [COLOR_W-1:0] g,
   output logic [COLOR_W-1:0] b,
   output logic               frame_tick,
   output logic [CNT_W-1:0]   frame_cnt,
   output logic [CNT_W-1:0]   scroll_cnt
);

   typedef enum logic [1:0] {
      MODE_BARS    = 2'd0,
      MODE_CHECKER = 2'd1,
      MODE_XOR     = 2'd2,
      MODE_FADE    = 2'd3
   } mode_t;

   // Level vsync rests at when not asserted.
   localparam logic VSYNC_IDLE = (VSYNC_ACT_LOW != 0) ? 1'b1 : 1'b0;

   logic               vsync_q;
   logic               vsync_on;
   logic               vsync_was_on;
   logic               tick;
   mode_t              mode_q;
   logic [CNT_W-1:0]   step;
   logic [CNT_W-1:0]   scroll_next;
   logic [COORD_W-1:0] scroll_ext;
   logic [COORD_W-1:0] mx;
   logic [COORD_W-1:0] my;
   logic [COLOR_W-1:0] col_r;
   logic [COLOR_W-1:0] col_g;
   logic [COLOR_W-1:0] col_b;

   // Channel slice of a coordinate-width value.
   function automatic logic [COLOR_W-1:0] chan(input logic [COORD_W-1:0] v);
      return v[SHIFT +: COLOR_W];
   endfunction

   // Edge detect on the asserted level; vsync_q resets to the idle level so the
   // first assertion after reset produces a tick.
   assign vsync_on     = (vsync != VSYNC_IDLE);
   assign vsync_was_on = (vsync_q != VSYNC_IDLE);
   assign tick         = vsync_on & ~vsync_was_on;

   assign step        = CNT_W'(speed);
   assign scroll_next = dir ? (scroll_cnt - step) : (scroll_cnt + step);

   assign scroll_ext = COORD_W'(scroll_cnt);
   assign mx         = pix_x + scroll_ext;
   assign my         = pix_y + scroll_ext;

   always_comb begin
      col_r = '0;
      col_g = '0;
      col_b = '0;
      unique case (mode_q)
         MODE_BARS: begin
            col_r = chan(mx);
            col_g = chan(mx << 1);
            col_b = chan(pix_y);
         end
         MODE_CHECKER: begin
            col_r = chan(mx ^ my);
            col_g = chan(mx ^ my);
            col_b = chan(mx ^ my);
         end
         MODE_XOR: begin
            col_r = chan(mx ^ pix_y);
            col_g = chan(pix_x ^ my);
            col_b = chan(mx & my);
         end
         MODE_FADE: begin
            col_r = chan(scroll_ext);
            col_g = chan(~scroll_ext);
            col_b = chan(scroll_ext << 1);
         end
         default: begin
            col_r = '0;
            col_g = '0;
            col_b = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q    <= VSYNC_IDLE;
         frame_tick <= 1'b0;
         frame_cnt  <= '0;
         scroll_cnt <= '0;
         mode_q     <= MODE_BARS;
         r          <= '0;
         g          <= '0;
         b          <= '0;
      end else begin
         vsync_q    <= vsync;
         frame_tick <= tick;
         if (tick) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
            mode_q    <= mode_t'(mode);
            if (!pause) begin
               scroll_cnt <= scroll_next;
            end
         end
         if (video_active) begin
            r <= col_r;
            g <= col_g;
            b <= col_b;
         end else begin
            r <= '0;
            g <= '0;
            b <= '0;
         end
      end
   end

endmodule
